// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : store_unit
//  Purpose  : Store-side memory write engine. Checks alignment of a store
//             request, packs the data into a big-endian 32-bit bus word with
//             byte enables, and runs one write transaction on the data bus
//             with a request/acknowledge handshake and a timeout.
//  Ports    :
//     clk, reset          core clock, synchronous active-high reset
//     storeStart          one-cycle request strobe (sampled in IDLE only)
//     storeSize           00 word, 01 half, 10 byte, 11 reserved
//     exceptionPending    drops a simultaneous request silently
//     calculatedAddress   byte address of the store
//     bRegister           store data
//     busAck, busError    slave response
//     busWriteReq         write request, held until response or timeout
//     busAddress          word-aligned address
//     busDataOut          lane-aligned write data
//     busByteEnable       bit 3 = lane [31:24] ... bit 0 = lane [7:0]
//     busy                transaction in flight
//     storeDone           one-cycle pulse on success
//     alignFault          one-cycle pulse on misaligned/reserved request
//     busFault            one-cycle pulse on bus error or timeout
//  Revision : 1.0  initial release
// ============================================================================
module store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        storeStart,
   input  logic [1:0]  storeSize,
   input  logic        exceptionPending,
   input  logic [31:0] calculatedAddress,
   input  logic [31:0] bRegister,
   input  logic        busAck,
   input  logic        busError,
   output logic        busWriteReq,
   output logic [31:0] busAddress,
   output logic [31:0] busDataOut,
   output logic [3:0]  busByteEnable,
   output logic        busy,
   output logic        storeDone,
   output logic        alignFault,
   output logic        busFault
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t             state;
   logic [TIMER_W-1:0] timer;

   logic               misaligned;
   logic [31:0]        pack_data;
   logic [3:0]         pack_be;

   // Alignment check and big-endian lane packing (offset 00 = lane [31:24]).
   always_comb begin
      misaligned = 1'b0;
      pack_data  = 32'h0;
      pack_be    = 4'b0000;
      case (storeSize)
         2'b00: begin
            misaligned = |calculatedAddress[1:0];
            pack_data  = bRegister;
            pack_be    = 4'b1111;
         end
         2'b01: begin
            misaligned = calculatedAddress[0];
            if (calculatedAddress[1]) begin
               pack_data = {16'h0, bRegister[15:0]};
               pack_be   = 4'b0011;
            end else begin
               pack_data = {bRegister[15:0], 16'h0};
               pack_be   = 4'b1100;
            end
         end
         2'b10: begin
            pack_be = 4'b1000 >> calculatedAddress[1:0];
            case (calculatedAddress[1:0])
               2'b00:   pack_data = {bRegister[7:0], 24'h0};
               2'b01:   pack_data = {8'h0, bRegister[7:0], 16'h0};
               2'b10:   pack_data = {16'h0, bRegister[7:0], 8'h0};
               default: pack_data = {24'h0, bRegister[7:0]};
            endcase
         end
         default: misaligned = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         timer         <= '0;
         busWriteReq   <= 1'b0;
         busAddress    <= 32'h0;
         busDataOut    <= 32'h0;
         busByteEnable <= 4'b0000;
         busy          <= 1'b0;
         storeDone     <= 1'b0;
         alignFault    <= 1'b0;
         busFault      <= 1'b0;
      end else begin
         // Status outputs are single-cycle pulses.
         storeDone  <= 1'b0;
         alignFault <= 1'b0;
         busFault   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (storeStart && !exceptionPending) begin
                  if (misaligned) begin
                     alignFault <= 1'b1;
                  end else begin
                     busAddress    <= {calculatedAddress[31:2], 2'b00};
                     busDataOut    <= pack_data;
                     busByteEnable <= pack_be;
                     busWriteReq   <= 1'b1;
                     busy          <= 1'b1;
                     timer         <= '0;
                     state         <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               // Error beats ack; any response beats the timeout.
               if (busError || busAck) begin
                  busWriteReq <= 1'b0;
                  busy        <= 1'b0;
                  storeDone   <= ~busError;
                  busFault    <= busError;
                  state       <= ST_IDLE;
               end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                  busWriteReq <= 1'b0;
                  busy        <= 1'b0;
                  busFault    <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_unit
//  Purpose  : Self-checking bench for store_unit. A default-timeout instance
//             handles packing/handshake/reset cases; a second instance with
//             TIMEOUT_CYCLES=4 handles the timeout boundary cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        storeStart;
   logic [1:0]  storeSize;
   logic        exceptionPending;
   logic [31:0] calculatedAddress;
   logic [31:0] bRegister;
   logic        busAck, busError;
   logic        busWriteReq, busy, storeDone, alignFault, busFault;
   logic [31:0] busAddress, busDataOut;
   logic [3:0]  busByteEnable;

   logic        t_start, t_ack, t_err;
   logic        t_req, t_busy, t_done, t_align, t_fault;
   logic [31:0] t_addr, t_data;
   logic [3:0]  t_be;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   store_unit dut (
      .clk(clk), .reset(reset), .storeStart(storeStart), .storeSize(storeSize),
      .exceptionPending(exceptionPending), .calculatedAddress(calculatedAddress),
      .bRegister(bRegister), .busAck(busAck), .busError(busError),
      .busWriteReq(busWriteReq), .busAddress(busAddress), .busDataOut(busDataOut),
      .busByteEnable(busByteEnable), .busy(busy), .storeDone(storeDone),
      .alignFault(alignFault), .busFault(busFault)
   );

   store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset), .storeStart(t_start), .storeSize(storeSize),
      .exceptionPending(exceptionPending), .calculatedAddress(calculatedAddress),
      .bRegister(bRegister), .busAck(t_ack), .busError(t_err),
      .busWriteReq(t_req), .busAddress(t_addr), .busDataOut(t_data),
      .busByteEnable(t_be), .busy(t_busy), .storeDone(t_done),
      .alignFault(t_align), .busFault(t_fault)
   );

   typedef struct {
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] bdata;
      logic        align;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic [3:0]  exp_be;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } txn_t;

   vec_t vecs[10];
   txn_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one store on the main instance; ack arrives after dly extra cycles.
   // poke pulses a second storeStart mid-transaction, which must be ignored.
   task automatic run_store(input vec_t v, input int dly, input bit poke);
      txn_t e;
      storeSize = v.size; calculatedAddress = v.addr; bRegister = v.bdata;
      storeStart = 1'b1;
      if (!v.align) sb.push_back('{v.exp_addr, v.exp_data, v.exp_be});
      @(posedge clk); #1 storeStart = 1'b0;
      @(negedge clk);
      if (v.align) begin
         check("align_pulse", {31'h0, alignFault}, 32'h1);
         check("align_noreq", {31'h0, busWriteReq}, 32'h0);
         check("align_busy", {31'h0, busy}, 32'h0);
         @(negedge clk);
         check("align_end", {31'h0, alignFault}, 32'h0);
         check("align_noreq2", {31'h0, busWriteReq}, 32'h0);
         return;
      end
      check("req_start", {31'h0, busWriteReq}, 32'h1);
      check("busy_start", {31'h0, busy}, 32'h1);
      if (sb.size() == 0) begin
         check("sb_empty", 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         check("addr", busAddress, e.addr);
         check("data", busDataOut, e.data);
         check("be", {28'h0, busByteEnable}, {28'h0, e.be});
      end
      for (int i = 0; i < dly; i++) begin
         @(posedge clk); #1;
         storeStart = 1'b0;
         if (poke && i == 1) begin
            storeStart = 1'b1; calculatedAddress = 32'h4444; bRegister = 32'h0;
         end
         @(negedge clk);
         check("hold_req", {31'h0, busWriteReq}, 32'h1);
         check("hold_data", busDataOut, e.data);
         check("hold_addr", busAddress, e.addr);
         check("hold_done", {31'h0, storeDone}, 32'h0);
      end
      storeStart = 1'b0;
      busAck = 1'b1;
      @(posedge clk); #1 busAck = 1'b0;
      @(negedge clk);
      check("done_pulse", {31'h0, storeDone}, 32'h1);
      check("done_req", {31'h0, busWriteReq}, 32'h0);
      check("done_busy", {31'h0, busy}, 32'h0);
      check("done_excl", {30'h0, alignFault, busFault}, 32'h0);
      @(negedge clk);
      check("done_single", {31'h0, storeDone}, 32'h0);
      check("no_second", {31'h0, busWriteReq}, 32'h0);
   endtask

   task automatic start_to();
      storeSize = 2'b00; calculatedAddress = 32'h5000; bRegister = 32'h11223344;
      t_start = 1'b1;
      @(posedge clk); #1 t_start = 1'b0;
   endtask

   initial begin
      int cnt;
      vecs[0] = '{2'b10, 32'h1000, 32'h000000A5, 1'b0, 32'h1000, 32'hA5000000, 4'b1000};
      vecs[1] = '{2'b10, 32'h1001, 32'h000000A5, 1'b0, 32'h1000, 32'h00A50000, 4'b0100};
      vecs[2] = '{2'b10, 32'h1002, 32'h000000A5, 1'b0, 32'h1000, 32'h0000A500, 4'b0010};
      vecs[3] = '{2'b10, 32'h1003, 32'h000000A5, 1'b0, 32'h1000, 32'h000000A5, 4'b0001};
      vecs[4] = '{2'b01, 32'h2002, 32'h1234BEEF, 1'b0, 32'h2000, 32'h0000BEEF, 4'b0011};
      vecs[5] = '{2'b01, 32'h2000, 32'h1234BEEF, 1'b0, 32'h2000, 32'hBEEF0000, 4'b1100};
      vecs[6] = '{2'b01, 32'h2001, 32'h1234BEEF, 1'b1, 32'h0,    32'h0,        4'b0000};
      vecs[7] = '{2'b00, 32'h3002, 32'hDEADBEEF, 1'b1, 32'h0,    32'h0,        4'b0000};
      vecs[8] = '{2'b11, 32'h3000, 32'hDEADBEEF, 1'b1, 32'h0,    32'h0,        4'b0000};
      vecs[9] = '{2'b00, 32'h3000, 32'hDEADBEEF, 1'b0, 32'h3000, 32'hDEADBEEF, 4'b1111};

      reset = 1'b1; storeStart = 1'b0; storeSize = 2'b00; exceptionPending = 1'b0;
      calculatedAddress = 32'h0; bRegister = 32'h0; busAck = 1'b0; busError = 1'b0;
      t_start = 1'b0; t_ack = 1'b0; t_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_req", {31'h0, busWriteReq}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_addr", busAddress, 32'h0);
      check("rst_pulses", {29'h0, storeDone, alignFault, busFault}, 32'h0);
      check("rst_to_req", {31'h0, t_req}, 32'h0);

      // Table: packing, alignment faults, ack on first WRITE cycle.
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         run_store(vecs[i], 0, 1'b0);
      end

      // Word store, ack delayed 5 cycles, with an ignored mid-flight start.
      @(posedge clk); #1;
      run_store(vecs[9], 5, 1'b1);

      // Timeout: busWriteReq high exactly 4 cycles, then busFault.
      @(posedge clk); #1;
      start_to();
      cnt = 0;
      @(negedge clk);
      while (t_req && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      check("to_cycles", cnt, 32'd4);
      check("to_fault", {31'h0, t_fault}, 32'h1);
      check("to_busy", {31'h0, t_busy}, 32'h0);
      check("to_nodone", {31'h0, t_done}, 32'h0);
      @(negedge clk);
      check("to_fault_end", {31'h0, t_fault}, 32'h0);

      // Ack and error together: error wins.
      @(posedge clk); #1;
      start_to();
      t_ack = 1'b1; t_err = 1'b1;
      @(posedge clk); #1 begin t_ack = 1'b0; t_err = 1'b0; end
      @(negedge clk);
      check("both_fault", {31'h0, t_fault}, 32'h1);
      check("both_nodone", {31'h0, t_done}, 32'h0);
      check("both_req", {31'h0, t_req}, 32'h0);

      // Ack in the expiry cycle beats the timeout.
      @(posedge clk); #1;
      start_to();
      repeat (3) @(posedge clk);
      #1 t_ack = 1'b1;
      @(posedge clk); #1 t_ack = 1'b0;
      @(negedge clk);
      check("exp_ack_done", {31'h0, t_done}, 32'h1);
      check("exp_ack_nofault", {31'h0, t_fault}, 32'h0);

      // Reset in the 2nd WRITE cycle.
      @(posedge clk); #1;
      storeSize = 2'b00; calculatedAddress = 32'h6000; bRegister = 32'hCAFEF00D;
      storeStart = 1'b1;
      @(posedge clk); #1 storeStart = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("mrst_req", {31'h0, busWriteReq}, 32'h0);
      check("mrst_busy", {31'h0, busy}, 32'h0);
      check("mrst_addr", busAddress, 32'h0);
      check("mrst_data", busDataOut, 32'h0);
      check("mrst_be", {28'h0, busByteEnable}, 32'h0);
      check("mrst_pulses", {29'h0, storeDone, alignFault, busFault}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mrst_nodone", {31'h0, storeDone}, 32'h0);
      end

      // Exception pending: request dropped silently.
      @(posedge clk); #1;
      storeSize = 2'b00; calculatedAddress = 32'h7000; bRegister = 32'h12345678;
      exceptionPending = 1'b1; storeStart = 1'b1;
      @(posedge clk); #1 begin storeStart = 1'b0; exceptionPending = 1'b0; end
      @(negedge clk);
      check("exc_req", {31'h0, busWriteReq}, 32'h0);
      check("exc_busy", {31'h0, busy}, 32'h0);
      check("exc_addr", busAddress, 32'h0);
      check("exc_pulses", {29'h0, storeDone, alignFault, busFault}, 32'h0);

      check("sb_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/store_unit.md
# store_unit

Store-side memory write engine for the cpu32e2 core. It takes a store request from the execute stage (register B value, calculated address, access size), checks alignment, and packs the data into a big-endian 32-bit bus word with byte enables. It then runs a single write transaction on the data bus with a request/acknowledge handshake and a timeout. It is the write-direction counterpart to the load extraction path that feeds the register file A write port.

## Interface
- TIMEOUT_CYCLES, 255: number of WRITE-state cycles without ack/error before the store is aborted as a bus fault (≥2).
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- storeStart  input  1  one-cycle request strobe; sampled only in IDLE.
- storeSize  input  2  00 = word (32b), 01 = half (16b), 10 = byte, 11 = reserved (treated as alignment fault).
- exceptionPending  input  1  when high together with storeStart, the request is dropped with no bus cycle and no status pulse.
- calculatedAddress  input  32  byte address of the store.
- bRegister  input  32  store data; the half uses [15:0], the byte uses [7:0].
- busAck  input  1  write accepted by the slave.
- busError  input  1  slave error response; ends the transaction.
- busWriteReq  output  1  write request, held until ack, error, or timeout.
- busAddress  output  32  word-aligned address {calculatedAddress[31:2], 2'b00}.
- busDataOut  output  32  lane-aligned write data.
- busByteEnable  output  4  bit 3 = lane [31:24] … bit 0 = lane [7:0].
- busy  output  1  a transaction is in flight.
- storeDone  output  1  one-cycle pulse on successful completion.
- alignFault  output  1  one-cycle pulse on a misaligned or reserved-size request.
- busFault  output  1  one-cycle pulse on busError or timeout.

## Operation
- States: IDLE and WRITE. All outputs are registered.
- IDLE, storeStart=1, exceptionPending=1: stay in IDLE; no outputs change.
- IDLE, storeStart=1, misaligned request:
  - Misaligned means half with address[0]=1, word with address[1:0]≠00, or size 11.
  - Pulse alignFault next cycle and stay in IDLE.
  - busWriteReq stays 0.
- IDLE, storeStart=1, aligned request:
  - Latch busAddress, busDataOut and busByteEnable, set busWriteReq=1 and busy=1, clear the timeout counter, and go to WRITE.
- Lane packing (big-endian; offset 00 is the most significant lane):
  - word: data = bRegister, enable = 1111.
  - half, address[1]=0: data = {h, 16'b0}, enable = 1100. Half, address[1]=1: data = {16'b0, h}, enable = 0011.
  - byte, offset k: the byte is placed in lane 3−k with the other lanes zero. Enable is 1000 >> k.
- WRITE state:
  - Outputs are held stable.
  - busAck=1: clear busWriteReq and busy, pulse storeDone, and go to IDLE.
  - busError=1: clear busWriteReq and busy, pulse busFault, and go to IDLE.
  - If busAck and busError are high together, busError wins.
  - Otherwise increment the counter (width $clog2(TIMEOUT_CYCLES+1)). When the counter equals TIMEOUT_CYCLES−1 and there is no ack or error, abort as for busError.
  - An ack or error in the same cycle as expiry wins over the timeout.
- storeStart while busy is ignored and not queued.
- reset, at any time including mid-WRITE:
  - Next edge returns to IDLE. busWriteReq, busy, storeDone, alignFault and busFault all go to 0.
  - busAddress, busDataOut, busByteEnable and the counter go to 0.
  - No completion pulse is produced for the aborted store.

## Timing
- storeStart sampled at edge N → busWriteReq=1 and busy=1 during cycle N+1.
- busAck sampled at edge M → during cycle M+1: busWriteReq=0, busy=0, storeDone=1.
- A new storeStart is accepted at edge M+1.
- The minimum store is 2 cycles from start to done (ack present in the first WRITE cycle), so back-to-back stores run one every 2 cycles.
- alignFault is high in cycle N+1 only.
- Timeout: with no response, busWriteReq is high for exactly TIMEOUT_CYCLES cycles, then busFault pulses for one cycle.
- Status pulses (storeDone, alignFault, busFault) are mutually exclusive and each lasts exactly one cycle.

## Test plan
- Byte stores at 0x1000–0x1003 with bRegister=0x000000A5, ack on the first WRITE cycle.
  - Expect data 0xA5000000/0x00A50000/0x0000A500/0x000000A5, enables 1000/0100/0010/0001, and busAddress 0x1000.
  - storeDone at N+2.
- Half store to 0x2002 with 0x1234BEEF → data 0x0000BEEF, enable 0011. Half store to 0x2001 → alignFault pulse, busWriteReq never asserted.
- Word store to 0x3000 with 0xDEADBEEF, ack delayed 5 cycles.
  - busWriteReq is high for 6 cycles with outputs stable.
  - A storeStart pulsed mid-transaction is ignored.
  - storeDone is a single pulse.
- With TIMEOUT_CYCLES=4 and no ack: busWriteReq high for exactly 4 cycles, then busFault pulse and busy=0.
  - Repeat with busAck and busError high together → busFault, not storeDone.
- Assert reset in the 2nd WRITE cycle → next cycle all outputs are 0 and no storeDone appears. storeStart with exceptionPending=1 → no bus activity and no status pulse.
